multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multicycle RV32I core. It sequences a shared ALU, a unified
//  instruction/data memory port and the register file across 3-5 cycles per instruction.
//  It drives every datapath mux select and write enable, and runs the memory handshake.
//  It traps on illegal opcodes and on memory timeouts.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a memory access may wait for mem_ready before TRAP (>=1)
// PORTS
//  clk        in   1  core clock; all state updates on rising edge
//  rst        in   1  asynchronous, active-high reset
//  op         in   7  instr[6:0] from instruction register
//  funct3_0   in   1  instr[12]: 0=beq, 1=bne
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory completes current access this cycle
//  mem_req    out  1  memory access request (held until mem_ready)
//  mem_we     out  1  memory write strobe (valid with mem_req)
//  adr_src    out  1  0=PC, 1=ALUOut as memory address
//  ir_write   out  1  load instruction register and OldPC
//  pc_write   out  1  PC load enable
//  reg_write  out  1  register file write enable
//  alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
//  alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
//  alu_op     out  2  00=add, 01=sub/compare, 10=funct-decoded
//  result_src out  2  00=ALUOut, 01=mem data, 10=ALU result (direct)
//  imm_src    out  2  00=I, 01=S, 10=B, 11=J; decoded from op every cycle
//  trap       out  1  sticky; set on illegal opcode or memory timeout
//  trap_cause out  1  0=illegal opcode, 1=memory timeout
// BEHAVIOUR
//  - Moore outputs decoded from the state register. Exception: pc_write/ir_write also use mem_ready and zero.
//  - While rst=1: state=FETCH, wait counter=0, trap=0, trap_cause=0.
//    pc_write, ir_write, reg_write, mem_req and mem_we are forced to 0.
//  - Unlisted outputs are 0 in each state. ALU mux selects default to 00.
//  - FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10.
//    When mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
//  - DECODE: alu_src_a=01, alu_src_b=01 (branch/jal target into ALUOut). Next state by op:
//    lw 0000011 or sw 0100011 -> MEMADR; R 0110011 -> EXEC_R; I 0010011 -> EXEC_I.
//    beq/bne 1100011 -> BRANCH; jal 1101111 -> JAL; jalr 1100111 -> JALR.
//    Any other op -> TRAP with trap_cause=0.
//  - MEMADR: src_a=10, src_b=01, alu_op=00. op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
//  - MEMREAD: mem_req=1, adr_src=1. On mem_ready -> MEMWB. MEMWB: result_src=01, reg_write=1 -> FETCH.
//  - MEMWRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready -> FETCH.
//  - EXEC_R: src_a=10, src_b=00, alu_op=10. EXEC_I: src_a=10, src_b=01, alu_op=10.
//    Both go to ALUWB. ALUWB: result_src=00, reg_write=1 -> FETCH.
//  - BRANCH: src_a=10, src_b=00, alu_op=01, result_src=00.
//    pc_write = zero ^ funct3_0. Next state FETCH.
//  - JAL: src_a=01, src_b=10, result_src=00, pc_write=1 -> ALUWB. PC<=target, ALUOut<=OldPC+4.
//  - JALR: src_a=10, src_b=01 -> JALR_PC.
//    JALR_PC: result_src=00, pc_write=1, src_a=01, src_b=10 -> ALUWB.
//    Target bit0 masking is done in the datapath.
//  - Wait counter: clears on entry to FETCH, MEMREAD or MEMWRITE and counts each cycle with mem_ready=0.
//    When it reaches MEM_TIMEOUT with mem_ready still 0: go to TRAP with trap_cause=1.
//    mem_ready in the timeout cycle wins; the access completes normally.
//  - TRAP: all enables 0, mem_req=0. Exit only by rst.
//  - mem_req is held stable until mem_ready. The address source does not change mid-access.
//  - A mem_ready seen outside a request state is ignored.
//  - Reset mid-access drops mem_req asynchronously. The memory must tolerate an abandoned request.
// STRUCTURE
//  - Package riscv_ctrl_pkg holds:
//    state encoding (4-bit, 14 states: FETCH=0 ... TRAP=13);
//    opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR;
//    SRC_A_*, SRC_B_*, ALUOP_*, RES_*, IMM_* select constants.
//  - One sub-module: mem_wait_timer (clk, rst, clear, busy, ready -> timeout), width $clog2(MEM_TIMEOUT+1).
//  - Everything else (next-state logic, output decode) is inline.
// TESTING
//  1 lw x5,8(x1), mem_ready=1 each access: FETCH,DECODE,MEMADR,MEMREAD,MEMWB (5 cycles).
//    reg_write=1 only in MEMWB, with result_src=01.
//  2 sw with mem_ready low 3 cycles in MEMWRITE: mem_req=1 and mem_we=1 held 4 cycles.
//    Then FETCH. reg_write never 1.
//  3 beq, zero=1: pc_write=1 in BRANCH. beq, zero=0: pc_write=0.
//    bne (funct3_0=1), zero=0: pc_write=1.
//  4 jal, then jalr: JAL->ALUWB and JALR->JALR_PC->ALUWB.
//    pc_write=1 exactly once after FETCH; reg_write=1 in ALUWB.
//  5 op=7'b1111111: DECODE->TRAP, trap=1, cause=0, stays 20 cycles.
//    FETCH with mem_ready=0 for MEM_TIMEOUT cycles: trap=1, cause=1.
//  6 rst pulsed mid-MEMREAD: mem_req drops same cycle, trap clears.
//    After release, state=FETCH and the first fetch completes normally.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: state codes, opcodes
// and datapath mux select values.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALR_PC  = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle. Memory handshake: mem_req (with mem_we,
// adr_src) is held stable until a cycle with mem_ready=1, which completes the access.
interface multicycle_controller_if;
  import riscv_ctrl_pkg::*;

  logic [6:0] op;
  logic       funct3_0;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic       trap;
  logic       trap_cause;
  state_t     state;

  modport master (
    input  op, funct3_0, zero, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           trap, trap_cause, state
  );

  modport slave (
    output op, funct3_0, zero, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           trap, trap_cause, state
  );
endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts stalled cycles of a memory access; flags the cycle in which the
// MEM_TIMEOUT-th consecutive not-ready cycle is seen.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  input  logic ready,
  output logic timeout
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clear)         cnt <= '0;
    else if (busy && !ready) cnt <= cnt + W'(1);
  end

  assign timeout = busy && !ready && (cnt == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_controller.sv
// Control FSM of the multicycle RV32I core: sequences ALU, shared memory port
// and register file, and traps on illegal opcodes or memory timeouts.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus
);
  state_t     state, next_state;
  logic       trap_q, cause_q;
  logic       timeout, mem_busy;
  logic       req, we, adr, irw, pcw, rw;
  logic [1:0] src_a, src_b, aluop, res;

  assign mem_busy = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);

  // Any state change restarts the wait count, so each access starts from zero.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (next_state != state),
    .busy    (mem_busy),
    .ready   (bus.mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q  <= 1'b0;
      cause_q <= 1'b0;
    end else if (state != TRAP && next_state == TRAP) begin
      trap_q  <= 1'b1;
      cause_q <= (state != DECODE);
    end
  end

  always_comb begin
    next_state = state;
    req   = 1'b0;
    we    = 1'b0;
    adr   = 1'b0;
    irw   = 1'b0;
    pcw   = 1'b0;
    rw    = 1'b0;
    src_a = SRC_A_PC;
    src_b = SRC_B_RS2;
    aluop = ALUOP_ADD;
    res   = RES_ALUOUT;
    unique case (state)
      FETCH: begin
        req   = 1'b1;
        src_b = SRC_B_FOUR;
        res   = RES_ALU;
        if (bus.mem_ready) begin
          irw        = 1'b1;
          pcw        = 1'b1;
          next_state = DECODE;
        end else if (timeout) begin
          next_state = TRAP;
        end
      end
      DECODE: begin
        src_a = SRC_A_OLDPC;
        src_b = SRC_B_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_R:              next_state = EXEC_R;
          OP_I:              next_state = EXEC_I;
          OP_BRANCH:         next_state = BRANCH;
          OP_JAL:            next_state = JAL;
          OP_JALR:           next_state = JALR;
          default:           next_state = TRAP;
        endcase
      end
      MEMADR: begin
        src_a      = SRC_A_RS1;
        src_b      = SRC_B_IMM;
        next_state = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        req = 1'b1;
        adr = 1'b1;
        if (bus.mem_ready) next_state = MEMWB;
        else if (timeout)  next_state = TRAP;
      end
      MEMWB: begin
        res        = RES_MEM;
        rw         = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        req = 1'b1;
        we  = 1'b1;
        adr = 1'b1;
        if (bus.mem_ready) next_state = FETCH;
        else if (timeout)  next_state = TRAP;
      end
      EXEC_R: begin
        src_a      = SRC_A_RS1;
        aluop      = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      EXEC_I: begin
        src_a      = SRC_A_RS1;
        src_b      = SRC_B_IMM;
        aluop      = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: begin
        rw         = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        src_a      = SRC_A_RS1;
        aluop      = ALUOP_SUB;
        pcw        = bus.zero ^ bus.funct3_0;
        next_state = FETCH;
      end
      // PC takes the target held in ALUOut while the ALU forms OldPC+4 for rd.
      JAL: begin
        src_a      = SRC_A_OLDPC;
        src_b      = SRC_B_FOUR;
        pcw        = 1'b1;
        next_state = ALUWB;
      end
      JALR: begin
        src_a      = SRC_A_RS1;
        src_b      = SRC_B_IMM;
        next_state = JALR_PC;
      end
      JALR_PC: begin
        src_a      = SRC_A_OLDPC;
        src_b      = SRC_B_FOUR;
        pcw        = 1'b1;
        next_state = ALUWB;
      end
      TRAP:    next_state = TRAP;
      default: next_state = FETCH;
    endcase
  end

  assign bus.mem_req    = req & ~rst;
  assign bus.mem_we     = we  & ~rst;
  assign bus.ir_write   = irw & ~rst;
  assign bus.pc_write   = pcw & ~rst;
  assign bus.reg_write  = rw  & ~rst;
  assign bus.adr_src    = adr;
  assign bus.alu_src_a  = src_a;
  assign bus.alu_src_b  = src_b;
  assign bus.alu_op     = aluop;
  assign bus.result_src = res;
  assign bus.imm_src    = imm_decode(bus.op);
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.state      = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into its expected
// per-cycle output trace and replayed against the DUT with random memory stalls.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  localparam int MT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller #(.MEM_TIMEOUT(MT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  int n_instr = 0;
  logic [21:0] exp_q[$];
  logic        rdy_q[$];
  logic        zr_q[$];
  logic [1:0]  cur_imm;
  logic        m_trap;
  logic        m_cause;
  logic [21:0] obs;

  assign obs = {bus.state, bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write,
                bus.pc_write, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.result_src, bus.imm_src, bus.trap, bus.trap_cause};

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (state %0d vs %0d)", tag, got, exp,
               got[21:18], exp[21:18]);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic is_legal(input logic [6:0] o);
    return o inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // en = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write}
  task automatic push(input logic rdy, input logic zr, input logic [3:0] st,
                      input logic [5:0] en, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] aop, input logic [1:0] res);
    exp_q.push_back({st, en, a, b, aop, res, cur_imm, m_trap, m_cause});
    rdy_q.push_back(rdy);
    zr_q.push_back(zr);
  endtask

  // A memory access stalls 'waits' cycles; MT or more stalls ends in a timeout trap.
  task automatic mem_access(input logic [3:0] st, input logic [5:0] en_wait,
                            input logic [5:0] en_done, input logic [1:0] a,
                            input logic [1:0] b, input logic [1:0] res,
                            input int waits, output logic timed_out);
    timed_out = 1'b0;
    if (waits >= MT) begin
      for (int i = 0; i < MT; i++) push(1'b0, rnd(), st, en_wait, a, b, 2'b00, res);
      m_trap    = 1'b1;
      m_cause   = 1'b1;
      timed_out = 1'b1;
    end else begin
      for (int i = 0; i < waits; i++) push(1'b0, rnd(), st, en_wait, a, b, 2'b00, res);
      push(1'b1, rnd(), st, en_done, a, b, 2'b00, res);
    end
  endtask

  task automatic plan_instr(input logic [6:0] o, input logic f3, input logic z,
                            input int fw, input int mw, output logic trapped);
    logic to;
    cur_imm = imm_of(o);
    trapped = 1'b0;
    mem_access(FETCH, 6'b100000, 6'b100110, 2'b00, 2'b10, 2'b10, fw, to);
    if (to) begin
      trapped = 1'b1;
      return;
    end
    push(rnd(), rnd(), DECODE, 6'b0, 2'b01, 2'b01, 2'b00, 2'b00);
    case (o)
      OP_LOAD: begin
        push(rnd(), rnd(), MEMADR, 6'b0, 2'b10, 2'b01, 2'b00, 2'b00);
        mem_access(MEMREAD, 6'b101000, 6'b101000, 2'b00, 2'b00, 2'b00, mw, to);
        if (!to) push(rnd(), rnd(), MEMWB, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b01);
        trapped = to;
      end
      OP_STORE: begin
        push(rnd(), rnd(), MEMADR, 6'b0, 2'b10, 2'b01, 2'b00, 2'b00);
        mem_access(MEMWRITE, 6'b111000, 6'b111000, 2'b00, 2'b00, 2'b00, mw, to);
        trapped = to;
      end
      OP_R: begin
        push(rnd(), rnd(), EXEC_R, 6'b0, 2'b10, 2'b00, 2'b10, 2'b00);
        push(rnd(), rnd(), ALUWB, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00);
      end
      OP_I: begin
        push(rnd(), rnd(), EXEC_I, 6'b0, 2'b10, 2'b01, 2'b10, 2'b00);
        push(rnd(), rnd(), ALUWB, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00);
      end
      OP_BRANCH: push(rnd(), z, BRANCH, {4'b0000, z ^ f3, 1'b0}, 2'b10, 2'b00, 2'b01, 2'b00);
      OP_JAL: begin
        push(rnd(), rnd(), JAL, 6'b000010, 2'b01, 2'b10, 2'b00, 2'b00);
        push(rnd(), rnd(), ALUWB, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00);
      end
      OP_JALR: begin
        push(rnd(), rnd(), JALR, 6'b0, 2'b10, 2'b01, 2'b00, 2'b00);
        push(rnd(), rnd(), JALR_PC, 6'b000010, 2'b01, 2'b10, 2'b00, 2'b00);
        push(rnd(), rnd(), ALUWB, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00);
      end
      default: begin
        m_trap  = 1'b1;
        m_cause = 1'b0;
        trapped = 1'b1;
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1; outputs are compared mid-cycle.
  task automatic drain();
    int cyc = 0;
    while (exp_q.size() > 0) begin
      bus.mem_ready = rdy_q.pop_front();
      bus.zero      = zr_q.pop_front();
      #1;
      check($sformatf("instr%0d_cyc%0d", n_instr, cyc), obs, exp_q.pop_front());
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    exp_q.delete();
    rdy_q.delete();
    zr_q.delete();
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b1;
    #1;
    m_trap  = 1'b0;
    m_cause = 1'b0;
    cur_imm = imm_of(bus.op);
    check(tag, obs, {FETCH, 6'b0, 2'b00, 2'b10, 2'b00, 2'b10, cur_imm, 2'b00});
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic f3, input logic z,
                           input int fw, input int mw);
    logic trapped;
    n_instr++;
    bus.op       = o;
    bus.funct3_0 = f3;
    plan_instr(o, f3, z, fw, mw, trapped);
    if (trapped)
      for (int i = 0; i < 20; i++)
        push(rnd(), rnd(), TRAP, 6'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    drain();
    if (trapped) do_reset("reset_after_trap");
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] op_tab[7];
  logic [6:0] o;

  initial begin
    op_tab = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR};
    bus.op        = OP_R;
    bus.funct3_0  = 1'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    m_trap        = 1'b0;
    m_cause       = 1'b0;
    cur_imm       = 2'b00;
    @(posedge clk);
    #1;
    do_reset("reset");

    run_instr(OP_LOAD,   1'b0, 1'b0, 0, 0);
    run_instr(OP_STORE,  1'b0, 1'b0, 0, 3);
    run_instr(OP_BRANCH, 1'b0, 1'b1, 0, 0);
    run_instr(OP_BRANCH, 1'b0, 1'b0, 0, 0);
    run_instr(OP_BRANCH, 1'b1, 1'b0, 0, 0);
    run_instr(OP_BRANCH, 1'b1, 1'b1, 1, 0);
    run_instr(OP_JAL,    1'b0, 1'b0, 0, 0);
    run_instr(OP_JALR,   1'b0, 1'b0, 0, 0);
    run_instr(OP_I,      1'b0, 1'b0, MT - 1, 0);
    run_instr(OP_LOAD,   1'b0, 1'b0, 0, MT - 1);
    run_instr(7'b1111111, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R,      1'b0, 1'b0, MT, 0);
    run_instr(OP_STORE,  1'b0, 1'b0, 2, MT);

    // Reset asserted while a load is stalled in MEMREAD.
    n_instr++;
    bus.op       = OP_LOAD;
    bus.funct3_0 = 1'b0;
    begin
      logic tr;
      plan_instr(OP_LOAD, 1'b0, 1'b0, 0, 6, tr);
    end
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rdy_q.pop_front();
      bus.zero      = zr_q.pop_front();
      #1;
      check($sformatf("rst_mid_read_cyc%0d", i), obs, exp_q.pop_front());
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    #2;
    do_reset("reset_mid_read");
    run_instr(OP_R, 1'b0, 1'b0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      int fw, mw;
      if ($urandom_range(0, 9) == 0) begin
        do o = 7'($urandom); while (is_legal(o));
      end else begin
        o = op_tab[$urandom_range(0, 6)];
      end
      fw = ($urandom_range(0, 19) == 0) ? MT : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? MT + $urandom_range(0, 2) : $urandom_range(0, 4);
      run_instr(o, rnd(), rnd(), fw, mw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
